// File: rtl/onchip_mem_pkg.sv
// Shared types and default sizing for the two-master on-chip memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package onchip_mem_pkg;

    // Arbiter ownership state: nobody, master 0 or master 1 holds the port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF    = 11;
    localparam int DATA_W_DEF    = 32;
    localparam int BURST_MAX_DEF = 8;

endpackage

// File: rtl/onchip_arb_hold_ctr.sv
// Counts consecutive granted cycles of the current owner and flags a forced handover.
// Latency: handover flag is combinational; counter updates on the next clk edge.
// Backpressure: none of its own; the handover flag makes the owner yield after BURST_MAX grants.
module onchip_arb_hold_ctr
    import onchip_mem_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic owned,      // FSM is in OWN0 or OWN1
    input  logic owner_req,  // current owner is requesting this cycle
    input  logic other_req,  // the non-owner is requesting this cycle
    input  logic any_req,    // a grant is issued this cycle
    output logic handover
);

    localparam int CNT_W = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(BURST_MAX - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // cnt = grants already given to the current owner in this run; the owner's
    // BURST_MAX-th grant happens while cnt == BURST_MAX-1.
    assign handover = owned && owner_req && other_req && (cnt >= LIMIT);

    // Next count: restart on handover, keep counting (saturating) while the owner
    // continues, start at 1 when a new owner takes its first grant, clear when idle.
    always_comb begin
        cnt_nxt = '0;
        if (handover) begin
            cnt_nxt = '0;
        end else if (owned && owner_req) begin
            cnt_nxt = (cnt >= LIMIT) ? cnt : cnt + ONE;
        end else if (any_req) begin
            cnt_nxt = ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter onto a single on-chip memory port; optional ONCHIP_ARB_ROUND_ROBIN_EN tie-break.
// Latency: grant/command combinational in the request cycle; read data returned one cycle later.
// Backpressure: losing requester held with waitrequest=1; owner yields after BURST_MAX grants if contended.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       req0, req1;
    logic       gnt0, gnt1;
    logic       owned, owner_req, other_req;
    logic       handover;
    logic       pick1;
    logic       rdv0, rdv1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    assign owned     = (state != IDLE);
    assign owner_req = (state == OWN0) ? req0 : (state == OWN1) ? req1 : 1'b0;
    assign other_req = (state == OWN0) ? req1 : (state == OWN1) ? req0 : 1'b0;

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    logic last_gnt1;

    // Remember who was granted last; starts as master 1 so master 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt1 <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_gnt1 <= gnt1;
        end
    end

    assign pick1 = ~last_gnt1;
`else
    assign pick1 = 1'b0;
`endif

    onchip_arb_hold_ctr #(
        .BURST_MAX (BURST_MAX)
    ) u_hold_ctr (
        .clk       (clk),
        .reset     (reset),
        .owned     (owned),
        .owner_req (owner_req),
        .other_req (other_req),
        .any_req   (req0 | req1),
        .handover  (handover)
    );

    // Ownership state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant and next owner: owner keeps the port while requesting unless a handover
    // is due; if it drops, a waiting master takes over the same cycle.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 && (!req1 || !pick1)) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                end else if (req1) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (req0) begin
                    gnt0      = 1'b1;
                    state_nxt = handover ? OWN1 : OWN0;
                end else if (req1) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                if (req1) begin
                    gnt1      = 1'b1;
                    state_nxt = handover ? OWN0 : OWN1;
                end else if (req0) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // No grant may leak out while reset is held.
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Memory command mux from the granted master; quiet port when nobody is granted.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        mem_chipselect = gnt0 | gnt1;
        if (gnt0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end else if (gnt1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end
    end

    // One-cycle read-return pipe; a read that also writes is a write and returns nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdv0 <= 1'b0;
            rdv1 <= 1'b0;
        end else begin
            rdv0 <= gnt0 & m0_read & ~m0_write;
            rdv1 <= gnt1 & m1_read & ~m1_write;
        end
    end

    assign mem_clken        = 1'b1;
    assign m0_waitrequest   = ~gnt0;
    assign m1_waitrequest   = ~gnt1;
    assign m0_readdatavalid = rdv0;
    assign m1_readdatavalid = rdv1;
    assign m0_readdata      = rdv0 ? mem_readdata : '0;
    assign m1_readdata      = rdv1 ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Testbench for onchip_mem_arbiter: directed scenarios plus random traffic vs a reference model.
// Latency: checks combinational grant mid-cycle, read return one cycle later.
// Backpressure: reference model tracks ownership runs and BURST_MAX handover.
module tb_onchip_mem_arbiter;

    localparam int BURST = 8;
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, reset;
    logic [10:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    onchip_mem_arbiter #(.ADDR_W(11), .DATA_W(32), .BURST_MAX(BURST)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: owner (-1 none), grants in current run, last granted master,
    // and which master has read data due next cycle.
    int m_owner, m_run, m_last;
    bit m_pend0, m_pend1;

    // Values observed in the most recent cycle, for directed checks.
    int          o_g;
    logic        o_rdv0, o_rdv1, o_mw, o_cs;
    logic [31:0] o_rd0, o_rd1, o_mwd;
    logic [10:0] o_maddr;
    logic [3:0]  o_mbe;
    bit          fix_mrd = 1'b0;
    logic [31:0] fix_val = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_last = 1; m_pend0 = 0; m_pend1 = 0;
    endtask

    function automatic int model_grant(input bit rq0, input bit rq1);
        bit rq[2];
        rq[0] = rq0; rq[1] = rq1;
        if (!rq0 && !rq1) return -1;
        if (m_owner == -1) begin
            if (rq0 && rq1) return (RR && m_last == 0) ? 1 : 0;
            return rq0 ? 0 : 1;
        end
        if (rq[m_owner]) return m_owner;
        return 1 - m_owner;
    endfunction

    task automatic model_step(input int g, input bit rq0, input bit rq1, input bit rd0, input bit rd1);
        bit rq[2];
        rq[0] = rq0; rq[1] = rq1;
        m_pend0 = (g == 0) && rd0;
        m_pend1 = (g == 1) && rd1;
        if (g == -1) begin
            m_owner = -1; m_run = 0;
        end else if (g == m_owner) begin
            m_run++;
            if (m_run >= BURST && rq[1 - g]) begin
                m_owner = 1 - g; m_run = 0;
            end
        end else begin
            m_owner = g; m_run = 1;
        end
        if (g != -1) m_last = g;
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks mid-cycle, returns at next posedge+1.
    task automatic cyc(input logic r0, input logic w0, input logic [10:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic [10:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1);
        int g;
        m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
        mem_readdata = fix_mrd ? fix_val : $urandom;
        #2;
        g = model_grant(r0 | w0, r1 | w1);
        chk("m0_waitrequest", m0_waitrequest, g != 0);
        chk("m1_waitrequest", m1_waitrequest, g != 1);
        chk("mem_chipselect", mem_chipselect, g != -1);
        chk("mem_write", mem_write, (g == 0) ? w0 : (g == 1) ? w1 : 1'b0);
        chk("mem_address", mem_address, (g == 0) ? a0 : (g == 1) ? a1 : 11'd0);
        chk("mem_byteenable", mem_byteenable, (g == 0) ? be0 : (g == 1) ? be1 : 4'd0);
        chk("mem_writedata", mem_writedata, (g == 0) ? d0 : (g == 1) ? d1 : 32'd0);
        chk("mem_clken", mem_clken, 1'b1);
        chk("m0_readdatavalid", m0_readdatavalid, m_pend0);
        chk("m1_readdatavalid", m1_readdatavalid, m_pend1);
        chk("m0_readdata", m0_readdata, m_pend0 ? mem_readdata : 32'd0);
        chk("m1_readdata", m1_readdata, m_pend1 ? mem_readdata : 32'd0);
        o_g = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
        o_rdv0 = m0_readdatavalid; o_rdv1 = m1_readdatavalid;
        o_rd0 = m0_readdata; o_rd1 = m1_readdata;
        o_mw = mem_write; o_mwd = mem_writedata; o_maddr = mem_address;
        o_mbe = mem_byteenable; o_cs = mem_chipselect;
        model_step(g, r0 | w0, r1 | w1, r0 & ~w0, r1 & ~w1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 11'd0, 4'd0, 32'd0, 0, 0, 11'd0, 4'd0, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wait0"}, m0_waitrequest, 1'b1);
        chk({tag, "_wait1"}, m1_waitrequest, 1'b1);
        chk({tag, "_rdv0"}, m0_readdatavalid, 1'b0);
        chk({tag, "_rdv1"}, m1_readdatavalid, 1'b0);
        chk({tag, "_rd0"}, m0_readdata, 32'd0);
        chk({tag, "_cs"}, mem_chipselect, 1'b0);
        chk({tag, "_mw"}, mem_write, 1'b0);
        chk({tag, "_maddr"}, mem_address, 11'd0);
        chk({tag, "_clken"}, mem_clken, 1'b1);
    endtask

    // Reset with an m0 read held through it; nothing may be granted or returned.
    task automatic do_reset();
        reset = 1'b1;
        m0_read = 1; m0_write = 0; m0_address = 11'h005; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
        mem_readdata = 32'hA5A5A5A5;
        #2;
        chk_reset_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic r0, w0, r1, w1;
        int   bias;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        idle();
        chk("post_reset_rdv0", o_rdv0, 1'b0);

        // m0 reads 0x005 alone; data arrives next cycle only for m0.
        cyc(1, 0, 11'h005, 4'hF, 32'd0, 0, 0, 11'd0, 4'd0, 32'd0);
        chk("r024_grant", o_g, 0);
        chk("r024_addr", o_maddr, 11'h005);
        fix_mrd = 1'b1; fix_val = 32'hDEADBEEF;
        idle();
        fix_mrd = 1'b0;
        chk("r024_rdv0", o_rdv0, 1'b1);
        chk("r024_rd0", o_rd0, 32'hDEADBEEF);
        chk("r024_rdv1", o_rdv1, 1'b0);
        chk("r024_rd1", o_rd1, 32'd0);

        // m1 read 0x7FF then m0 write 0x000 back-to-back.
        cyc(0, 0, 11'd0, 4'd0, 32'd0, 1, 0, 11'h7FF, 4'hF, 32'd0);
        chk("r027_grant1", o_g, 1);
        cyc(0, 1, 11'h000, 4'hF, 32'h12345678, 0, 0, 11'd0, 4'd0, 32'd0);
        chk("r027_rdv1", o_rdv1, 1'b1);
        chk("r027_rdv0", o_rdv0, 1'b0);
        chk("r027_mw", o_mw, 1'b1);
        chk("r027_mwd", o_mwd, 32'h12345678);
        chk("r027_maddr", o_maddr, 11'h000);
        idle();
        chk("r027_rdv1_once", o_rdv1, 1'b0);

        // m0 read and write in the same cycle is a write with no data return.
        cyc(1, 1, 11'h033, 4'h3, 32'hCAFEF00D, 0, 0, 11'd0, 4'd0, 32'd0);
        chk("r028_mw", o_mw, 1'b1);
        chk("r028_be", o_mbe, 4'h3);
        idle();
        chk("r028_rdv0", o_rdv0, 1'b0);

        // Simultaneous requests from idle, twice, starting from reset.
        do_reset();
        idle();
        cyc(0, 1, 11'h010, 4'hF, 32'h1, 0, 1, 11'h020, 4'hF, 32'h2);
        chk("r026_first", o_g, 0);
        idle();
        cyc(0, 1, 11'h011, 4'hF, 32'h3, 0, 1, 11'h021, 4'hF, 32'h4);
        chk("r026_second", o_g, RR ? 1 : 0);
        idle();

        // Continuous writes from both: grants alternate in runs of exactly BURST.
        for (int k = 0; k < 5 * BURST; k++) begin
            cyc(0, 1, 11'(k), 4'hF, 32'(k), 0, 1, 11'(k + 100), 4'hF, 32'(k + 100));
            chk("r025_run", o_g, (k / BURST) % 2);
            chk("r025_cs", o_cs, 1'b1);
        end
        idle();

        // Random traffic with varying request density.
        for (int k = 0; k < 600; k++) begin
            bias = (k < 300) ? 4 : 8;
            r0 = ($urandom_range(0, 9) < bias);
            w0 = ($urandom_range(0, 9) < bias / 2);
            r1 = ($urandom_range(0, 9) < bias);
            w1 = ($urandom_range(0, 9) < bias / 2);
            cyc(r0, w0, 11'($urandom), 4'($urandom), $urandom,
                r1, w1, 11'($urandom), 4'($urandom), $urandom);
        end
        idle();

        // Reset asserted in the middle of a granted read.
        m0_read = 1; m0_write = 0; m0_address = 11'h055; m0_byteenable = 4'hF;
        m1_read = 0; m1_write = 0;
        #1;
        chk("r023_pre_grant", m0_waitrequest, 1'b0);
        reset = 1'b1;
        #1;
        chk("r023_wait0", m0_waitrequest, 1'b1);
        chk("r023_wait1", m1_waitrequest, 1'b1);
        chk("r023_cs", mem_chipselect, 1'b0);
        chk("r023_state", 32'(dut.state), 32'd0);
        @(posedge clk);
        #1;
        chk("r023_rdv0", m0_readdatavalid, 1'b0);
        chk("r023_rdv1", m1_readdatavalid, 1'b0);
        reset = 1'b0;
        model_reset();
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
